// File: rtl/fm_nco_mod.sv
// -----------------------------------------------------------------------------
// fm_nco_mod
// NCO-based FM transmitter. Audio samples arrive in offset binary and queue in a
// small FIFO. A divider releases one sample per audio-sample period. Each
// released sample becomes a frequency control word: the carrier plus the signed
// audio, shifted left by DEV_SHIFT. The FCW drives a phase accumulator, and the
// accumulator MSB, registered, is the 1-bit RF output.
//
// Optional feature macro: FM_PREEMPH_EN
//   When defined, a first-order pre-emphasis stage is placed between the held
//   sample and the FCW mapping. This stage adds one register of latency.
//
// Ports
//   clk          in   1        system clock
//   rst_n        in   1        asynchronous active-low reset
//   en           in   1        1 = run divider/accumulator, 0 = freeze them
//   carrier_fcw  in   PHASE_W  carrier frequency control word
//   s_valid      in   1        audio sample valid
//   s_ready      out  1        FIFO not full
//   s_data       in   AUDIO_W  audio sample, offset binary
//   sample_tick  out  1        pulse at each audio-sample boundary
//   underrun     out  1        pulse when a tick finds the FIFO empty
//   phase_out    out  PHASE_W  phase accumulator value
//   fm_out       out  1        registered phase MSB
// -----------------------------------------------------------------------------
module fm_nco_mod #(
    parameter int AUDIO_W    = 10,
    parameter int PHASE_W    = 32,
    parameter int SAMPLE_DIV = 43334,
    parameter int DEV_SHIFT  = 8,
    parameter int DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] carrier_fcw,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [AUDIO_W-1:0] s_data,
    output logic               sample_tick,
    output logic               underrun,
    output logic [PHASE_W-1:0] phase_out,
    output logic               fm_out
);

    localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    // The deviation is computed at a width that holds both the carrier word
    // and the (AUDIO_W+1)-bit mapped sample. Sign extension then stays correct
    // even when PHASE_W is narrower than the audio word.
    localparam int EXT_W = (PHASE_W > AUDIO_W + 1) ? PHASE_W : AUDIO_W + 1;

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [PTR_W:0]     FIFO_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [AUDIO_W-1:0] MID_SCALE = {1'b1, {(AUDIO_W - 1){1'b0}}};

    logic [CNT_W-1:0]   cnt_q;
    logic [AUDIO_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic [AUDIO_W-1:0] cur_sample_q;
    logic [PHASE_W-1:0] fcw_q, fcw_d;
    logic [PHASE_W-1:0] phase_q;
    logic               fm_q;

    logic fifo_empty, push, pop;
    logic signed [AUDIO_W-1:0] off;
    logic signed [AUDIO_W:0]   mapped;
    logic signed [EXT_W-1:0]   dev_ext;
    logic signed [EXT_W-1:0]   dev_shifted;

    assign fifo_empty  = (count_q == '0);
    assign s_ready     = (count_q != FIFO_FULL);
    assign sample_tick = en && (cnt_q == CNT_LAST);
    assign underrun    = sample_tick && fifo_empty;
    assign push        = s_valid && s_ready;
    assign pop         = sample_tick && !fifo_empty;

    // Inverting the MSB converts offset binary to two's complement.
    assign off = $signed({~cur_sample_q[AUDIO_W-1], cur_sample_q[AUDIO_W-2:0]});

`ifdef FM_PREEMPH_EN
    logic signed [AUDIO_W-1:0] off_prev_q;
    logic signed [AUDIO_W:0]   emph_q;
    logic signed [AUDIO_W+1:0] diff, emph_sum;
    logic signed [AUDIO_W:0]   emph_d;

    // y = off + (off - off_prev)/4. The result saturates to AUDIO_W+1 bits
    // whenever the two top bits of the wider sum disagree.
    always_comb begin
        diff     = (AUDIO_W + 2)'(off) - (AUDIO_W + 2)'(off_prev_q);
        emph_sum = (AUDIO_W + 2)'(off) + (diff >>> 2);
        emph_d   = emph_sum[AUDIO_W:0];
        if (emph_sum[AUDIO_W+1] != emph_sum[AUDIO_W]) begin
            emph_d = emph_sum[AUDIO_W+1] ? {1'b1, {AUDIO_W{1'b0}}}
                                         : {1'b0, {AUDIO_W{1'b1}}};
        end
    end

    // off_prev captures the outgoing sample on each tick, so after the tick
    // the difference is taken between consecutive samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_prev_q <= '0;
            emph_q     <= '0;
        end else begin
            if (sample_tick) off_prev_q <= off;
            if (en)          emph_q     <= emph_d;
        end
    end

    assign mapped = emph_q;
`else
    assign mapped = (AUDIO_W + 1)'(off);
`endif

    always_comb begin
        dev_ext     = EXT_W'(mapped);
        dev_shifted = dev_ext <<< DEV_SHIFT;
        fcw_d       = carrier_fcw + dev_shifted[PHASE_W-1:0];
    end

    // The FIFO storage is written without a reset. Entries are only read
    // after they have been pushed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    // Control state. Pushes are accepted even while en is low. A pop, and with
    // it the update of the held sample, happens only on a tick that finds data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cur_sample_q <= MID_SCALE;
            fcw_q        <= '0;
            phase_q      <= '0;
            fm_q         <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q     <= rd_ptr_q + 1'b1;
                cur_sample_q <= mem_q[rd_ptr_q];
            end
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;

            if (en) begin
                cnt_q   <= sample_tick ? '0 : cnt_q + 1'b1;
                fcw_q   <= fcw_d;
                phase_q <= phase_q + fcw_q;
                fm_q    <= phase_q[PHASE_W-1];
            end
        end
    end

    assign phase_out = phase_q;
    assign fm_out    = fm_q;

endmodule

// File: tb/tb_fm_nco_mod.sv
// -----------------------------------------------------------------------------
// tb_fm_nco_mod
// Self-checking bench for fm_nco_mod. It uses an 8-bit phase, 10-bit audio, a
// 16-cycle sample period, no deviation shift and a 4-entry FIFO.
// The reference model tracks the audio queue, the held sample and the
// accumulator arithmetically, using integer math. Every cycle it predicts the
// tick, underrun, ready, phase and RF output.
// -----------------------------------------------------------------------------
module tb_fm_nco_mod;

    localparam int AW    = 10;
    localparam int PW    = 8;
    localparam int DIV   = 16;
    localparam int SHIFT = 0;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [PW-1:0] carrier_fcw;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] s_data;
    logic          sample_tick;
    logic          underrun;
    logic [PW-1:0] phase_out;
    logic          fm_out;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model state: the audio queue, the sample currently in use,
    // the word the accumulator adds next, the phase, and the RF bit.
    int mCnt;
    int mQ[$];
    int mCur;
    int mFcw;
    int mPhase;
    int mFm;

    fm_nco_mod #(
        .AUDIO_W   (AW),
        .PHASE_W   (PW),
        .SAMPLE_DIV(DIV),
        .DEV_SHIFT (SHIFT),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .carrier_fcw(carrier_fcw),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .sample_tick(sample_tick),
        .underrun   (underrun),
        .phase_out  (phase_out),
        .fm_out     (fm_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCompared++;
        assert (obs === expv)
        else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        mCnt   = 0;
        mQ.delete();
        mCur   = 1 << (AW - 1);
        mFcw   = 0;
        mPhase = 0;
        mFm    = 0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_phase", 32'(phase_out), 0);
        checkOutput("rst_fm", 32'(fm_out), 0);
        checkOutput("rst_ready", 32'(s_ready), 1);
        checkOutput("rst_tick", 32'(sample_tick), 0);
        checkOutput("rst_underrun", 32'(underrun), 0);
    endtask

    // Drives one cycle of inputs. Before the edge, the task checks the
    // combinational outputs. It then advances the model and, once the edge
    // has passed, checks the registered outputs.
    task automatic applyStimulus(input bit enV, input bit vV, input int dV, input int carV);
        bit tick, rdy, und;
        int nextCur;
        int dev;
        en          = enV;
        s_valid     = vV;
        s_data      = dV[AW-1:0];
        carrier_fcw = carV[PW-1:0];
        #2;
        tick = enV && (mCnt == DIV - 1);
        rdy  = mQ.size() < DEPTH;
        und  = tick && (mQ.size() == 0);
        checkOutput("sample_tick", 32'(sample_tick), 32'(tick));
        checkOutput("underrun", 32'(underrun), 32'(und));
        checkOutput("s_ready", 32'(s_ready), 32'(rdy));

        nextCur = mCur;
        if (tick && mQ.size() > 0) nextCur = mQ.pop_front();
        if (vV && rdy) mQ.push_back(dV & ((1 << AW) - 1));
        if (enV) begin
            dev    = (mCur - (1 << (AW - 1))) * (1 << SHIFT);
            mFm    = (mPhase >> (PW - 1)) & 1;
            mPhase = (mPhase + mFcw) & ((1 << PW) - 1);
            mFcw   = (carV + dev) & ((1 << PW) - 1);
            mCnt   = (mCnt + 1) % DIV;
        end
        mCur = nextCur;

        @(posedge clk);
        #1;
        checkOutput("phase_out", 32'(phase_out), 32'(mPhase));
        checkOutput("fm_out", 32'(fm_out), 32'(mFm));
    endtask

    // Applies reset partway through a cycle, checks the cleared outputs while
    // reset is held, and releases reset before the next clock edge.
    task automatic midReset();
        rst_n = 1'b0;
        #2;
        modelReset();
        checkResetState();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int car;
        rst_n       = 1'b0;
        en          = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        carrier_fcw = '0;
        modelReset();
        #12;
        checkResetState();
        rst_n = 1'b1;

        $display("[TB] Step 1: carrier 0x80, no audio");
        for (int i = 0; i < 40; i++) applyStimulus(1, 0, 0, 8'h80);

        $display("[TB] Step 2: carrier 0x40, mid-scale sample");
        applyStimulus(1, 1, 10'h200, 8'h40);
        for (int i = 0; i < 40; i++) applyStimulus(1, 0, 0, 8'h40);

        $display("[TB] Step 3: deviation up then down");
        applyStimulus(1, 1, 10'h240, 8'h40);
        for (int i = 0; i < 40; i++) applyStimulus(1, 0, 0, 8'h40);
        applyStimulus(1, 1, 10'h1C0, 8'h40);
        for (int i = 0; i < 40; i++) applyStimulus(1, 0, 0, 8'h40);

        $display("[TB] Step 4: FIFO full back-pressure");
        for (int i = 0; i < 24; i++) applyStimulus(1, 1, 10'h100 + i * 7, 8'h40);
        for (int i = 0; i < 70; i++) applyStimulus(1, 0, 0, 8'h40);

        $display("[TB] Step 5: underruns, then en low");
        for (int i = 0; i < 3 * DIV + 4; i++) applyStimulus(1, 0, 0, 8'h33);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 8'h55);
        applyStimulus(0, 1, 10'h3FF, 8'h55);
        for (int i = 0; i < DIV + 2; i++) applyStimulus(1, 0, 0, 8'h55);

        $display("[TB] Step 6: reset with queued samples");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 10'h2A0 + i, 8'h21);
        midReset();
        for (int i = 0; i < 2 * DIV + 4; i++) applyStimulus(1, 0, 0, 8'h21);

        $display("[TB] Step 7: randomized traffic");
        car = int'($urandom_range(0, 255));
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 49) == 0) car = int'($urandom_range(0, 255));
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                          int'($urandom_range(0, 1023)), car);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
